fetch_queue: RTL and testbench

Instruction fetch front-end of the AtomRV32I pipeline, sitting directly upstream of the decode stage. It generates sequential word addresses, issues pipelined requests to instruction memory, buffers returned instructions with their PCs in a small FIFO, and presents them to decode with a valid/ready handshake. A redirect from execute (taken jump/branch) flushes the queue and discards in-flight responses.

---
 rtl/fetch_queue.sv | 111 +++++++++++
 tb/tb_fetch_queue.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues sequential word-address requests, buffers {pc, instr}
// pairs and hands them to decode. FETCH_BYPASS_EN enables a zero-latency empty-queue bypass.
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] PC_RESET = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic [XLEN-1:0] pc_mem  [DEPTH];
  logic [XLEN-1:0] ins_mem [DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count, outstanding, drop;
  logic [XLEN-1:0] req_pc, rsp_pc;
  logic            running;

  logic [CW:0] in_use;
  logic        credit, req_fire, fifo_empty, rsp_keep, push, pop;

  // Handshakes: a transfer happens on a cycle where valid and ready are both high;
  // valid never depends on ready, and the payload is held while valid & !ready.
  assign in_use         = {1'b0, count} + {1'b0, outstanding};
  assign credit         = in_use < DEPTH_C;
  assign imem_req_valid = running & credit & ~redirect_valid;
  assign imem_addr      = req_pc;
  assign req_fire       = imem_req_valid & imem_req_ready;
  assign fifo_empty     = (count == '0);
  assign rsp_keep       = imem_rsp_valid & (drop == '0);
  assign pop            = ~fifo_empty & instr_ready & ~redirect_valid;

`ifdef FETCH_BYPASS_EN
  logic bypass;
  assign bypass      = fifo_empty & rsp_keep & ~redirect_valid;
  // A bypassed response consumed by decode this cycle never enters the FIFO.
  assign push        = rsp_keep & ~(bypass & instr_ready);
  assign instr_valid = ~fifo_empty | bypass;
  assign instr       = bypass ? imem_rsp_data : ins_mem[rd_ptr];
  assign instr_pc    = bypass ? rsp_pc : pc_mem[rd_ptr];
`else
  assign push        = rsp_keep;
  assign instr_valid = ~fifo_empty;
  assign instr       = ins_mem[rd_ptr];
  assign instr_pc    = pc_mem[rd_ptr];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running     <= 1'b0;
      req_pc      <= PC_RESET;
      rsp_pc      <= PC_RESET;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]  <= PC_RESET;
        ins_mem[i] <= '0;
      end
    end else begin
      running <= 1'b1;
      if (redirect_valid) begin
        // Everything still in flight belongs to the old path, including a
        // response landing in this very cycle.
        req_pc      <= redirect_pc;
        rsp_pc      <= redirect_pc;
        count       <= '0;
        rd_ptr      <= '0;
        wr_ptr      <= '0;
        outstanding <= outstanding - CW'(imem_rsp_valid);
        drop        <= outstanding - CW'(imem_rsp_valid);
      end else begin
        if (req_fire)
          req_pc <= req_pc + XLEN'(1);
        outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
        if (imem_rsp_valid) begin
          if (drop != '0)
            drop <= drop - CW'(1);
          else
            rsp_pc <= rsp_pc + XLEN'(1);
        end
        if (push) begin
          pc_mem[wr_ptr]  <= rsp_pc;
          ins_mem[wr_ptr] <= imem_rsp_data;
          wr_ptr          <= wr_ptr + AW'(1);
        end
        if (pop)
          rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: in-order memory model, PC scoreboard, directed timing checks.
// Build with +define+FETCH_BYPASS_EN to check the bypass variant.
module tb_fetch_queue;

`ifdef FETCH_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  fetch_queue #(.XLEN(32), .DEPTH(4), .PC_RESET(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int lat      = 1;
  bit lat_rand = 1'b0;
  bit rand_ready = 1'b0;
  int acc_cnt  = 0;
  int deliv_cnt = 0;
  int max_cnt  = 0;
  bit hold_prev = 1'b0;
  logic [31:0] hold_pc = '0;
  logic [31:0] exp_q[$];
  logic [31:0] pend_addr[$];
  int          pend_due[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hDEAD_BEEF;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- memory model: in-order, per-request latency ----------------
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (rst_n && pend_addr.size() > 0 && pend_due[0] <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
      end
      if (rand_ready)
        imem_req_ready = ($urandom_range(0, 2) != 0);
    end
  end

  // ---------------- monitor + scoreboard ----------------
  always @(negedge clk) begin
    logic [31:0] e;
    if (!rst_n) begin
      hold_prev = 1'b0;
    end else begin
      if (int'(dut.count) > max_cnt)
        max_cnt = int'(dut.count);
      if (hold_prev) begin
        check("hold_valid", 32'(instr_valid), 32'd1);
        check("hold_pc", instr_pc, hold_pc);
      end
      if (imem_req_valid && imem_req_ready) begin
        pend_addr.push_back(imem_addr);
        pend_due.push_back(cyc + (lat_rand ? int'($urandom_range(1, 4)) : lat));
        exp_q.push_back(imem_addr);
        acc_cnt++;
      end
      if (!redirect_valid && instr_valid && instr_ready) begin
        deliv_cnt++;
        if (exp_q.size() == 0) begin
          check("sb_nonempty", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("sb_pc", instr_pc, e);
          check("sb_instr", instr, mem_word(e));
        end
      end
      if (redirect_valid)
        exp_q.delete();
      hold_prev = instr_valid && !instr_ready && !redirect_valid;
      hold_pc   = instr_pc;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int l, input logic ir);
    next_cycle();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = ir;
    rand_ready     = 1'b0;
    imem_req_ready = 1'b1;
    lat            = l;
    lat_rand       = 1'b0;
    pend_addr.delete();
    pend_due.delete();
    exp_q.delete();
    acc_cnt   = 0;
    deliv_cnt = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic wait_first(input logic [31:0] pc, input int exp_k);
    int k;
    k = 0;
    while (!instr_valid && k < 30) begin
      @(negedge clk);
      k++;
    end
    check("first_pc", instr_pc, pc);
    check("first_instr", instr, mem_word(pc));
    check("first_lat", 32'(k), 32'(exp_k));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int d0;
    // Reset values, with the memory offering ready throughout
    repeat (2) @(negedge clk);
    check("reset_req_valid", 32'(imem_req_valid), 32'd0);
    check("reset_addr", imem_addr, 32'h0);
    check("reset_instr_valid", 32'(instr_valid), 32'd0);
    check("reset_instr", instr, 32'h0);
    check("reset_instr_pc", instr_pc, 32'h0);

    // Test 1: latency 1, decode always ready
    do_reset(1, 1'b1);
    next_cycle();
    @(negedge clk);
    check("t1_first_req", 32'(imem_req_valid), 32'd1);
    check("t1_first_addr", imem_addr, 32'h0);
    check("t1_valid_c0", 32'(instr_valid), 32'd0);
    next_cycle();
    @(negedge clk);
    check("t1_valid_c1", 32'(instr_valid), 32'(BYP));
    check("t1_addr_c1", imem_addr, 32'h1);
    next_cycle();
    @(negedge clk);
    check("t1_valid_c2", 32'(instr_valid), 32'd1);
    check("t1_pc_c2", instr_pc, (BYP == 1) ? 32'h1 : 32'h0);
    next_cycle();
    d0 = deliv_cnt;
    repeat (16) next_cycle();
    check("t1_throughput", 32'(deliv_cnt - d0), 32'd16);

    // Test 2: decode stalled for 10 cycles, then drains
    do_reset(1, 1'b0);
    repeat (10) next_cycle();
    check("t2_accepts", 32'(acc_cnt), 32'd4);
    @(negedge clk);
    check("t2_req_blocked", 32'(imem_req_valid), 32'd0);
    check("t2_valid", 32'(instr_valid), 32'd1);
    check("t2_head_pc", instr_pc, 32'h0);
    check("t2_head_instr", instr, mem_word(32'h0));
    next_cycle();
    instr_ready = 1'b1;
    d0 = deliv_cnt;
    repeat (8) next_cycle();
    check("t2_drain", 32'(deliv_cnt - d0), 32'd8);

    // Test 3: latency 3, redirect with three requests in flight
    do_reset(3, 1'b1);
    repeat (4) next_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    @(negedge clk);
    check("t3_req_in_redirect", 32'(imem_req_valid), 32'd0);
    check("t3_valid_in_redirect", 32'(instr_valid), 32'd0);
    next_cycle();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("t3_req_after", 32'(imem_req_valid), 32'd1);
    check("t3_addr_after", imem_addr, 32'h40);
    wait_first(32'h40, 4 - BYP);
    repeat (4) next_cycle();

    // Test 4: latency 2 steady stream, redirect meets a response and a pop; target wraps
    do_reset(2, 1'b1);
    repeat (7) next_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFE;
    @(negedge clk);
    check("t4_req_in_redirect", 32'(imem_req_valid), 32'd0);
    next_cycle();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("t4_empty_after", 32'(instr_valid), 32'd0);
    check("t4_addr_after", imem_addr, 32'hFFFF_FFFE);
    wait_first(32'hFFFF_FFFE, 3 - BYP);
    repeat (6) next_cycle();

    // Test 5: random ready, latency and decode backpressure with sparse redirects
    do_reset(1, 1'b1);
    lat_rand   = 1'b1;
    rand_ready = 1'b1;
    for (int i = 0; i < 800; i++) begin
      next_cycle();
      instr_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = ($urandom_range(0, 2) == 0) ? 32'hFFFF_FFFD : $urandom;
      end else begin
        redirect_valid = 1'b0;
      end
    end
    next_cycle();
    rand_ready     = 1'b0;
    imem_req_ready = 1'b0;
    redirect_valid = 1'b0;
    instr_ready    = 1'b1;
    repeat (20) next_cycle();
    check("t5_drained", 32'(exp_q.size()), 32'd0);
    check("t5_mem_idle", 32'(pend_addr.size()), 32'd0);
    check("t5_count_bound", 32'(max_cnt <= 4), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
